// File: rtl/spram_ctrl.sv
// Single-port RAM command/response controller with a 2-entry response buffer.
// Define SPRAM_CTRL_WR_ACK_EN to make writes return an acknowledge response.
module spram_ctrl #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [WIDTH-1:0]      cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
`ifdef SPRAM_CTRL_WR_ACK_EN
  output logic                  rsp_wr,
`endif
  output logic                  ram_rst,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WIDTH-1:0]      ram_din,
  input  logic [WIDTH-1:0]      ram_dout
);

  logic             infl;
  logic             infl_nxt;
  logic [1:0]       cnt;
  logic [1:0]       occ;
  logic             room;
  logic             acc;
  logic             push;
  logic             pop;
  logic             wp;
  logic             rp;
  logic [WIDTH-1:0] bd [2];
  logic [WIDTH-1:0] push_d;

  assign occ  = cnt + {1'b0, infl};
  assign room = (occ < 2'd2);

`ifdef SPRAM_CTRL_WR_ACK_EN
  logic infl_wr;
  logic bw [2];

  assign cmd_ready = rst_n & room;
  assign infl_nxt  = acc;
  assign push_d    = infl_wr ? '0 : ram_dout;
  assign rsp_wr    = rsp_valid & bw[rp];
`else
  // Writes never occupy the buffer, so they are always accepted.
  assign cmd_ready = rst_n & (cmd_we | room);
  assign infl_nxt  = acc & ~cmd_we;
  assign push_d    = ram_dout;
`endif

  assign acc       = cmd_valid & cmd_ready;
  assign push      = infl;
  assign rsp_valid = (cnt != 2'd0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = bd[rp];

  assign ram_rst  = ~rst_n;
  assign ram_we   = acc & cmd_we;
  assign ram_addr = cmd_addr;
  assign ram_din  = cmd_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl  <= 1'b0;
      cnt   <= 2'd0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      bd[0] <= '0;
      bd[1] <= '0;
    end else begin
      infl <= infl_nxt;
      if (push) begin
        bd[wp] <= push_d;
        wp     <= ~wp;
      end
      if (pop)
        rp <= ~rp;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef SPRAM_CTRL_WR_ACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_wr <= 1'b0;
      bw[0]   <= 1'b0;
      bw[1]   <= 1'b0;
    end else begin
      infl_wr <= acc & cmd_we;
      if (push)
        bw[wp] <= infl_wr;
    end
  end
`endif

endmodule
